mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 ex_valid  in  1  execute stage presents an operation.
REQ-005 ex_ready  out  1  stage accepts the operation this cycle.
REQ-006 alu_result  in  32  effective address, or the writeback value for non-memory operations.
REQ-007 store_data  in  32  rs2 value for stores.
REQ-008 MemRead, MemWrite, MemSize, MemtoReg, RegWrite  in  1 each  decoded controls, meanings as in the controller.
REQ-009 load_signed  in  1  1 = sign-extend byte load (lb); 0 = zero-extend (lbu).
REQ-010 rd  in  5  destination register index.
REQ-011 wr_valid  out  1  writeback payload valid.
REQ-012 wr_ready  in  1  writeback accepts the payload.
REQ-013 wr_data  out  32  value to write to rd.
REQ-014 wr_rd  out  5  destination register index.
REQ-015 wr_regwrite  out  1  register-file write enable.
REQ-016 misalign  out  1  one-cycle pulse on a rejected misaligned word access.
REQ-017 mem_cyc, mem_stb, mem_we  out  1 each  Wishbone-classic master cycle, strobe and write-enable.
REQ-018 mem_adr  out  32  bus address.
REQ-019 mem_dat_o  out  32  bus write data.
REQ-020 mem_sel  out  4  byte-lane selects.
REQ-021 mem_dat_i  in  32  bus read data.
REQ-022 mem_ack  in  1  bus acknowledge.

Function
REQ-023 A handshake SHALL occur when ex_valid && ex_ready.
REQ-024 ex_ready SHALL be high only in IDLE, or in HOLD while wr_ready is high.
REQ-025 The FSM SHALL have three states: IDLE, BUS, HOLD.
REQ-026 Non-memory operation (MemRead=MemWrite=0) accepted: next state HOLD; wr_data=alu_result, wr_regwrite=RegWrite; latency one cycle.
REQ-027 Memory operation accepted: next state BUS; latch address, data, sel and we; mem_cyc=mem_stb=1 from the next cycle.
REQ-028 If MemRead and MemWrite are both high, MemWrite SHALL take priority.
REQ-029 In BUS, cyc, stb, adr, dat_o, sel and we SHALL be held stable until mem_ack.
REQ-030 In BUS, no timeout SHALL apply.
REQ-031 On the mem_ack cycle, the FSM SHALL go to HOLD and drop cyc/stb on the next edge.
REQ-032 On mem_ack for a load, the extended read data SHALL be captured into wr_data.
REQ-033 On mem_ack for a store, wr_regwrite SHALL be 0.
REQ-034 Byte access (MemSize=0): sel = 4'b0001 << alu_result[1:0]; mem_dat_o = store_data[7:0] replicated to all four lanes.
REQ-035 Byte load SHALL select lane alu_result[1:0] and extend per load_signed.
REQ-036 Word access (MemSize=1): sel = 4'b1111; mem_dat_o = store_data; load data passed unmodified.
REQ-037 mem_adr SHALL equal alu_result unmodified.
REQ-038 Word access with alu_result[1:0] != 0: no bus cycle; go directly to HOLD with wr_regwrite=0; pulse misalign for one cycle.
REQ-039 In HOLD, wr_valid SHALL be 1.
REQ-040 In HOLD with wr_ready=1 and a new handshake, the new operation SHALL be taken with no bubble.
REQ-041 In HOLD with wr_ready=1 and no new handshake, next state SHALL be IDLE.
REQ-042 In HOLD with wr_ready=0, all wr_* outputs SHALL be held.
REQ-043 mem_ack outside BUS SHALL be ignored.

Reset
REQ-044 Reset assertion SHALL force IDLE immediately, regardless of clk, including mid-BUS.
REQ-045 While reset is asserted, and on release: mem_cyc, mem_stb, mem_we, wr_valid, wr_regwrite, misalign = 0; mem_adr, mem_dat_o, wr_data = 0; mem_sel = 0; wr_rd = 0.
REQ-046 ex_ready SHALL be 0 while reset is asserted.
REQ-047 ex_ready SHALL be 1 in the first cycle after release.

Structure
REQ-048 The FSM state enum, bus width constant (32) and sel width constant (4) SHALL live in the shared core package beside alu_ops_t.
REQ-049 One sub-module, load_extend, SHALL be combinational: inputs read data, lane, MemSize, load_signed; output 32-bit result.

Verification
REQ-050 ALU op alu_result=0x0000_1234, RegWrite=1, rd=5, wr_ready=1 -> next cycle wr_valid=1, wr_data=0x1234, wr_rd=5; no mem_cyc.
REQ-051 lb at 0x103, signed, mem_dat_i=0x80FF_0000 returned with ack after 3 wait cycles -> sel=4'b1000 held 4 cycles; wr_data=0xFFFF_FF80.
REQ-052 sb at 0x102, store_data=0x0000_00AB -> mem_we=1, sel=4'b0100, dat_o=0xABAB_ABAB; wr_regwrite=0.
REQ-053 lw at 0x0000_0006 -> no mem_cyc; misalign pulses once; wr_valid with wr_regwrite=0.
REQ-054 Back-to-back ALU ops with wr_ready=1 -> one result per cycle; wr_ready=0 for 2 cycles -> ex_ready=0 and wr_data stable.
REQ-055 Reset asserted while in BUS before ack -> mem_cyc/mem_stb drop asynchronously; a late ack after release is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared core package for the pipeline.
// Holds the ALU operation encoding, the memory-stage FSM state type,
// the data-bus and byte-select widths, and a helper that builds a
// one-hot byte-lane select from a byte offset.
package mem_stage_pkg;

  localparam int unsigned XLEN  = 32;  // bus / register width
  localparam int unsigned SEL_W = 4;   // byte lanes on the bus

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ops_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_t;

  // One-hot lane select for a byte access at the given address offset.
  function automatic logic [SEL_W-1:0] byte_sel(input logic [1:0] lane);
    return {{(SEL_W-1){1'b0}}, 1'b1} << lane;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// load_extend: combinational load-data formatter.
//   rdata       in  32  raw bus read data
//   lane        in  2   byte offset of the access
//   MemSize     in  1   1 = word (pass through), 0 = byte
//   load_signed in  1   byte loads: 1 = sign-extend, 0 = zero-extend
//   result      out 32  value to write back
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      lane,
  input  logic            MemSize,
  input  logic            load_signed,
  output logic [XLEN-1:0] result
);

  logic [7:0] lane_byte [SEL_W];
  logic [7:0] sel_byte;

  genvar gi;
  generate
    for (gi = 0; gi < SEL_W; gi++) begin : g_lane
      assign lane_byte[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = lane_byte[lane];

  always_comb begin
    result = rdata;
    if (!MemSize) begin
      result = {{(XLEN-8){load_signed & sel_byte[7]}}, sel_byte};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a Wishbone-classic master port.
//   clk, reset (async, active-low)
//   ex_*        : operation from execute (valid/ready handshake)
//   alu_result  : effective address or writeback value
//   store_data, MemRead, MemWrite, MemSize, MemtoReg, RegWrite,
//   load_signed, rd : decoded operation fields
//   wr_*        : writeback payload (valid/ready handshake)
//   misalign    : one-cycle pulse on a rejected misaligned word access
//   mem_*       : Wishbone-classic master signals
// States: IDLE (empty), BUS (waiting for mem_ack), HOLD (result presented).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  store_data,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             MemSize,
  input  logic             MemtoReg,
  input  logic             RegWrite,
  input  logic             load_signed,
  input  logic [4:0]       rd,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [XLEN-1:0]  wr_data,
  output logic [4:0]       wr_rd,
  output logic             wr_regwrite,
  output logic             misalign,
  output logic             mem_cyc,
  output logic             mem_stb,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_adr,
  output logic [XLEN-1:0]  mem_dat_o,
  output logic [SEL_W-1:0] mem_sel,
  input  logic [XLEN-1:0]  mem_dat_i,
  input  logic             mem_ack
);

  mem_state_t        state_reg;
  logic [4:0]        pend_rd_reg;
  logic              pend_regwrite_reg;
  logic              pend_load_reg;     // capture bus data (else alu_result)
  logic              pend_size_reg;
  logic              pend_signed_reg;

  logic              accept;
  logic              is_mem;
  logic              misaligned;
  logic [SEL_W-1:0]  op_sel;
  logic [XLEN-1:0]   op_dat;
  logic [XLEN-1:0]   ext_data;

  // Gated by reset so nothing is accepted while the stage is held in reset.
  assign ex_ready = reset && ((state_reg == ST_IDLE) ||
                              ((state_reg == ST_HOLD) && wr_ready));
  assign wr_valid = (state_reg == ST_HOLD);
  assign accept   = ex_valid && ex_ready;

  assign is_mem     = MemRead || MemWrite;
  assign misaligned = MemSize && (alu_result[1:0] != 2'b00);
  assign op_sel     = MemSize ? {SEL_W{1'b1}} : byte_sel(alu_result[1:0]);
  assign op_dat     = MemSize ? store_data : {SEL_W{store_data[7:0]}};

  // The latched address supplies the lane; it is stable for the whole cycle.
  load_extend u_load_extend (
    .rdata       (mem_dat_i),
    .lane        (mem_adr[1:0]),
    .MemSize     (pend_size_reg),
    .load_signed (pend_signed_reg),
    .result      (ext_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= ST_IDLE;
      pend_rd_reg       <= '0;
      pend_regwrite_reg <= 1'b0;
      pend_load_reg     <= 1'b0;
      pend_size_reg     <= 1'b0;
      pend_signed_reg   <= 1'b0;
      wr_data           <= '0;
      wr_rd             <= '0;
      wr_regwrite       <= 1'b0;
      misalign          <= 1'b0;
      mem_cyc           <= 1'b0;
      mem_stb           <= 1'b0;
      mem_we            <= 1'b0;
      mem_adr           <= '0;
      mem_dat_o         <= '0;
      mem_sel           <= '0;
    end else begin
      misalign <= 1'b0;
      // accept is only possible in IDLE or in HOLD with wr_ready, so a
      // new operation from HOLD is taken with no bubble.
      if (accept) begin
        if (!is_mem || misaligned) begin
          // Result available immediately; misaligned words never reach the bus.
          state_reg   <= ST_HOLD;
          wr_data     <= alu_result;
          wr_rd       <= rd;
          wr_regwrite <= RegWrite && !is_mem;
          misalign    <= is_mem;
        end else begin
          state_reg         <= ST_BUS;
          mem_cyc           <= 1'b1;
          mem_stb           <= 1'b1;
          mem_we            <= MemWrite;   // write wins if both are set
          mem_adr           <= alu_result;
          mem_dat_o         <= op_dat;
          mem_sel           <= op_sel;
          pend_rd_reg       <= rd;
          pend_regwrite_reg <= RegWrite && !MemWrite;
          pend_load_reg     <= !MemWrite && MemtoReg;
          pend_size_reg     <= MemSize;
          pend_signed_reg   <= load_signed;
        end
      end else begin
        case (state_reg)
          ST_BUS: begin
            if (mem_ack) begin
              state_reg   <= ST_HOLD;
              mem_cyc     <= 1'b0;
              mem_stb     <= 1'b0;
              mem_we      <= 1'b0;
              wr_rd       <= pend_rd_reg;
              wr_regwrite <= pend_regwrite_reg;
              wr_data     <= pend_load_reg ? ext_data : mem_adr;
            end
          end
          ST_HOLD: begin
            if (wr_ready) begin
              state_reg <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: hand-computed expected values,
// one line per transaction, summary line at the end.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, MemSize = 1'b0;
  logic        MemtoReg = 1'b0, RegWrite = 1'b0, load_signed = 1'b0;
  logic [4:0]  rd = '0;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [31:0] wr_data;
  logic [4:0]  wr_rd;
  logic        wr_regwrite;
  logic        misalign;
  logic        mem_cyc, mem_stb, mem_we;
  logic [31:0] mem_adr, mem_dat_o;
  logic [3:0]  mem_sel;
  logic [31:0] mem_dat_i = '0;
  logic        mem_ack = 1'b0;

  int check_cnt = 0;
  int pass_cnt  = 0;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .store_data(store_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .load_signed(load_signed),
    .rd(rd),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_rd(wr_rd), .wr_regwrite(wr_regwrite), .misalign(misalign),
    .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_dat_o(mem_dat_o), .mem_sel(mem_sel),
    .mem_dat_i(mem_dat_i), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] sd,
                        input logic rdn, input logic wrn, input logic sz,
                        input logic m2r, input logic rw, input logic sgn,
                        input logic [4:0] dst);
    ex_valid = 1'b1; alu_result = a; store_data = sd;
    MemRead = rdn; MemWrite = wrn; MemSize = sz; MemtoReg = m2r;
    RegWrite = rw; load_signed = sgn; rd = dst;
  endtask

  initial begin
    // ---- reset ----
    tick(); tick();
    check_value("rst_ex_ready", 32'(ex_ready), 32'd0);
    check_value("rst_cyc", 32'(mem_cyc), 32'd0);
    check_value("rst_wr_valid", 32'(wr_valid), 32'd0);
    check_value("rst_wr_data", wr_data, 32'd0);
    check_value("rst_sel", 32'(mem_sel), 32'd0);
    reset = 1'b1;
    #1;
    check_value("rel_ex_ready", 32'(ex_ready), 32'd1);
    $display("txn reset: ex_ready=%0b", ex_ready);

    // ---- ALU op ----
    set_op(32'h0000_1234, 0, 0, 0, 0, 0, 1, 0, 5'd5);
    tick(); ex_valid = 1'b0;
    check_value("alu_wr_valid", 32'(wr_valid), 32'd1);
    check_value("alu_wr_data", wr_data, 32'h0000_1234);
    check_value("alu_wr_rd", 32'(wr_rd), 32'd5);
    check_value("alu_regwrite", 32'(wr_regwrite), 32'd1);
    check_value("alu_no_cyc", 32'(mem_cyc), 32'd0);
    $display("txn alu: wr_data=0x%08h rd=%0d", wr_data, wr_rd);
    tick();
    check_value("alu_idle", 32'(wr_valid), 32'd0);

    // ---- lb 0x103 signed, ack after 3 wait cycles ----
    set_op(32'h0000_0103, 0, 1, 0, 0, 1, 1, 1, 5'd7);
    tick(); ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_value("lb_cyc", 32'(mem_cyc & mem_stb), 32'd1);
      check_value("lb_sel", 32'(mem_sel), 32'h8);
      check_value("lb_adr", mem_adr, 32'h0000_0103);
      check_value("lb_ex_ready", 32'(ex_ready), 32'd0);
      if (i == 3) begin mem_ack = 1'b1; mem_dat_i = 32'h80FF_0000; end
      tick();
    end
    mem_ack = 1'b0;
    check_value("lb_cyc_drop", 32'(mem_cyc), 32'd0);
    check_value("lb_wr_data", wr_data, 32'hFFFF_FF80);
    check_value("lb_wr_rd", 32'(wr_rd), 32'd7);
    check_value("lb_regwrite", 32'(wr_regwrite), 32'd1);
    $display("txn lb: wr_data=0x%08h", wr_data);
    tick();

    // ---- lbu 0x101, immediate ack ----
    set_op(32'h0000_0101, 0, 1, 0, 0, 1, 1, 0, 5'd8);
    tick(); ex_valid = 1'b0;
    check_value("lbu_sel", 32'(mem_sel), 32'h2);
    mem_ack = 1'b1; mem_dat_i = 32'h0000_9A00;
    tick(); mem_ack = 1'b0;
    check_value("lbu_wr_data", wr_data, 32'h0000_009A);
    $display("txn lbu: wr_data=0x%08h", wr_data);
    tick();

    // ---- sb 0x102 ----
    set_op(32'h0000_0102, 32'h0000_00AB, 0, 1, 0, 0, 0, 0, 5'd0);
    tick(); ex_valid = 1'b0;
    check_value("sb_we", 32'(mem_we), 32'd1);
    check_value("sb_sel", 32'(mem_sel), 32'h4);
    check_value("sb_dat", mem_dat_o, 32'hABAB_ABAB);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    check_value("sb_wr_valid", 32'(wr_valid), 32'd1);
    check_value("sb_regwrite", 32'(wr_regwrite), 32'd0);
    $display("txn sb: dat_o=0x%08h", mem_dat_o);
    tick();

    // ---- sw with MemRead and MemWrite both set: write wins ----
    set_op(32'h0000_0020, 32'hDEAD_BEEF, 1, 1, 1, 1, 1, 0, 5'd9);
    tick(); ex_valid = 1'b0;
    check_value("sw_we", 32'(mem_we), 32'd1);
    check_value("sw_sel", 32'(mem_sel), 32'hF);
    check_value("sw_dat", mem_dat_o, 32'hDEAD_BEEF);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    check_value("sw_regwrite", 32'(wr_regwrite), 32'd0);
    $display("txn sw: dat_o=0x%08h", mem_dat_o);
    tick();

    // ---- lw 0x6 misaligned ----
    set_op(32'h0000_0006, 0, 1, 0, 1, 1, 1, 0, 5'd4);
    tick(); ex_valid = 1'b0;
    check_value("mis_cyc", 32'(mem_cyc), 32'd0);
    check_value("mis_pulse", 32'(misalign), 32'd1);
    check_value("mis_wr_valid", 32'(wr_valid), 32'd1);
    check_value("mis_regwrite", 32'(wr_regwrite), 32'd0);
    tick();
    check_value("mis_pulse_end", 32'(misalign), 32'd0);
    check_value("mis_no_cyc", 32'(mem_cyc), 32'd0);
    $display("txn lw_misaligned: misalign pulsed");

    // ---- back-to-back ALU ops, then stall ----
    set_op(32'h0000_00A1, 0, 0, 0, 0, 0, 1, 0, 5'd1);
    tick();
    check_value("b2b_a", wr_data, 32'h0000_00A1);
    set_op(32'h0000_00B2, 0, 0, 0, 0, 0, 1, 0, 5'd2);
    tick();
    check_value("b2b_b", wr_data, 32'h0000_00B2);
    check_value("b2b_b_rd", 32'(wr_rd), 32'd2);
    set_op(32'h0000_00C3, 0, 0, 0, 0, 0, 1, 0, 5'd3);
    wr_ready = 1'b0;
    #1;
    check_value("stall_ex_ready", 32'(ex_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_value("stall_data", wr_data, 32'h0000_00B2);
      check_value("stall_valid", 32'(wr_valid), 32'd1);
      check_value("stall_ready", 32'(ex_ready), 32'd0);
    end
    wr_ready = 1'b1;
    #1;
    check_value("unstall_ready", 32'(ex_ready), 32'd1);
    tick(); ex_valid = 1'b0;
    check_value("b2b_c", wr_data, 32'h0000_00C3);
    $display("txn b2b: last wr_data=0x%08h", wr_data);
    tick();

    // ---- async reset mid-BUS, late ack ignored ----
    set_op(32'h0000_0010, 0, 1, 0, 1, 1, 1, 0, 5'd6);
    tick(); ex_valid = 1'b0;
    check_value("rb_cyc", 32'(mem_cyc), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_value("rb_cyc_drop", 32'(mem_cyc), 32'd0);
    check_value("rb_stb_drop", 32'(mem_stb), 32'd0);
    check_value("rb_ex_ready", 32'(ex_ready), 32'd0);
    #1 reset = 1'b1;
    mem_ack = 1'b1; mem_dat_i = 32'h1111_2222;
    tick(); mem_ack = 1'b0;
    check_value("late_ack_valid", 32'(wr_valid), 32'd0);
    check_value("late_ack_cyc", 32'(mem_cyc), 32'd0);
    check_value("late_ack_ready", 32'(ex_ready), 32'd1);
    $display("txn reset_mid_bus: cyc=%0b wr_valid=%0b", mem_cyc, wr_valid);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Safety net in case the run stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
